// File: rtl/prbs7_checker.sv
// Serial PRBS7 (x^7 + x^6 + 1) checker: seeds from the stream, locks, then counts bit errors.
// Optional macro PRBS7_CHECKER_BITCNT_EN adds a saturating count of bits checked while locked.
module prbs7_checker #(
  parameter int unsigned LOCK_CNT = 8,
  parameter int unsigned LOSS_CNT = 4,
  parameter int unsigned ERR_W    = 8
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             din,
  input  logic             din_valid,
  input  logic             clr_cnt,
  output logic             locked,
  output logic             err,
  output logic [ERR_W-1:0] err_cnt
`ifdef PRBS7_CHECKER_BITCNT_EN
  , output logic [15:0]    bit_cnt
`endif
);

  typedef enum logic [1:0] {StSeed, StCheck, StLocked} state_e;

  localparam logic [7:0] LockCnt = 8'(LOCK_CNT);
  localparam logic [3:0] LossCnt = 4'(LOSS_CNT);

  state_e           state_q, state_d;
  logic [6:0]       s_q, s_d;
  logic [2:0]       seed_q, seed_d;
  logic [7:0]       match_q, match_d;
  logic [3:0]       loss_q, loss_d;
  logic             locked_q, locked_d;
  logic             err_q, err_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

  logic       exp_bit;
  logic       s_zero;
  logic       mism;
  logic [7:0] match_inc;
  logic [3:0] loss_inc;

  always_comb begin
    exp_bit   = s_q[6] ^ s_q[5];
    s_zero    = (s_q == 7'd0);
    mism      = (din != exp_bit);
    match_inc = match_q + 8'd1;
    loss_inc  = loss_q + 4'd1;

    state_d   = state_q;
    s_d       = s_q;
    seed_d    = seed_q;
    match_d   = match_q;
    loss_d    = loss_q;
    err_d     = 1'b0;
    err_cnt_d = err_cnt_q;

    if (din_valid) begin
      unique case (state_q)
        StSeed: begin
          s_d = {s_q[5:0], din};
          if (seed_q == 3'd6) begin
            state_d = StCheck;
            seed_d  = 3'd0;
            match_d = 8'd0;
          end else begin
            seed_d = seed_q + 3'd1;
          end
        end
        StCheck: begin
          s_d = {s_q[5:0], din};
          // An all-zero register can never come from a real PRBS7 stream.
          if (mism || s_zero) begin
            state_d = StSeed;
            seed_d  = 3'd0;
          end else if (match_inc == LockCnt) begin
            state_d = StLocked;
            loss_d  = 4'd0;
            match_d = match_inc;
          end else begin
            match_d = match_inc;
          end
        end
        StLocked: begin
          // Free-run on the predicted bit so a bad input bit does not corrupt later predictions.
          s_d = {s_q[5:0], exp_bit};
          if (s_zero) begin
            state_d = StSeed;
            seed_d  = 3'd0;
          end else if (!mism) begin
            loss_d = 4'd0;
          end else begin
            err_d = 1'b1;
            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + ERR_W'(1);
            if (loss_inc == LossCnt) begin
              state_d = StSeed;
              seed_d  = 3'd0;
              loss_d  = 4'd0;
            end else begin
              loss_d = loss_inc;
            end
          end
        end
        default: begin
          state_d = StSeed;
          seed_d  = 3'd0;
        end
      endcase
    end

    if (clr_cnt) err_cnt_d = '0;
    locked_d = (state_d == StLocked);
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q   <= StSeed;
      s_q       <= 7'd0;
      seed_q    <= 3'd0;
      match_q   <= 8'd0;
      loss_q    <= 4'd0;
      locked_q  <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      s_q       <= s_d;
      seed_q    <= seed_d;
      match_q   <= match_d;
      loss_q    <= loss_d;
      locked_q  <= locked_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign locked  = locked_q;
  assign err     = err_q;
  assign err_cnt = err_cnt_q;

`ifdef PRBS7_CHECKER_BITCNT_EN
  logic [15:0] bit_cnt_q, bit_cnt_d;

  always_comb begin
    bit_cnt_d = bit_cnt_q;
    if (din_valid && (state_q == StLocked) && (bit_cnt_q != 16'hFFFF)) begin
      bit_cnt_d = bit_cnt_q + 16'd1;
    end
    if (clr_cnt) bit_cnt_d = 16'd0;
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      bit_cnt_q <= 16'd0;
    end else begin
      bit_cnt_q <= bit_cnt_d;
    end
  end

  assign bit_cnt = bit_cnt_q;
`endif

endmodule

// File: tb/tb_prbs7_checker.sv
// Directed bench for prbs7_checker: two instances (ERR_W=8 and ERR_W=2) fed the same stream.
// Expected outputs are queued when a bit is driven and checked after the sampling edge.
module tb_prbs7_checker;

  logic       clk = 1'b0;
  logic       clrn;
  logic       din;
  logic       din_valid;
  logic       clr_cnt;
  logic       locked, err, locked_s, err_s;
  logic [7:0] err_cnt;
  logic [1:0] err_cnt_s;
`ifdef PRBS7_CHECKER_BITCNT_EN
  logic [15:0] bit_cnt, bit_cnt_s;
`endif

  always #5 clk = ~clk;

  prbs7_checker #(.LOCK_CNT(8), .LOSS_CNT(4), .ERR_W(8)) dut (
    .clk       (clk),
    .clrn      (clrn),
    .din       (din),
    .din_valid (din_valid),
    .clr_cnt   (clr_cnt),
    .locked    (locked),
    .err       (err),
    .err_cnt   (err_cnt)
`ifdef PRBS7_CHECKER_BITCNT_EN
    , .bit_cnt (bit_cnt)
`endif
  );

  prbs7_checker #(.LOCK_CNT(8), .LOSS_CNT(4), .ERR_W(2)) dut_s (
    .clk       (clk),
    .clrn      (clrn),
    .din       (din),
    .din_valid (din_valid),
    .clr_cnt   (clr_cnt),
    .locked    (locked_s),
    .err       (err_s),
    .err_cnt   (err_cnt_s)
`ifdef PRBS7_CHECKER_BITCNT_EN
    , .bit_cnt (bit_cnt_s)
`endif
  );

  typedef struct {
    logic        lock;
    logic        er;
    logic [7:0]  cnt;
    logic [1:0]  cnt_s;
    logic [15:0] bits;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad = 0;
  logic [6:0]  g;
  logic [7:0]  e8;
  logic [1:0]  e2;
  logic [15:0] eb;
  logic        pl;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  task automatic compare_pop();
    exp_t x;
    x = sb.pop_front();
    chk("locked", {15'd0, locked}, {15'd0, x.lock});
    chk("err", {15'd0, err}, {15'd0, x.er});
    chk("err_cnt", {8'd0, err_cnt}, {8'd0, x.cnt});
    chk("locked_w2", {15'd0, locked_s}, {15'd0, x.lock});
    chk("err_cnt_w2", {14'd0, err_cnt_s}, {14'd0, x.cnt_s});
`ifdef PRBS7_CHECKER_BITCNT_EN
    chk("bit_cnt", bit_cnt, x.bits);
`endif
  endtask

  task automatic step_raw(input logic d, input logic v, input logic clr, input logic lk,
                          input logic er);
    exp_t x;
    din       = d;
    din_valid = v;
    clr_cnt   = clr;
    if (clr) eb = 16'd0;
    else if (v && pl && eb != 16'hFFFF) eb = eb + 16'd1;
    x = '{lock: lk, er: er, cnt: e8, cnt_s: e2, bits: eb};
    sb.push_back(x);
    @(posedge clk);
    #1;
    compare_pop();
    pl = lk;
  endtask

  // Drives the next generator bit (optionally inverted); idle cycles carry random junk.
  task automatic gstep(input logic inv, input logic v, input logic clr, input logic lk,
                       input logic er);
    logic b;
    b = g[6] ^ g[5];
    if (v) begin
      g = {g[5:0], b};
      step_raw(b ^ inv, 1'b1, clr, lk, er);
    end else begin
      step_raw(1'($urandom), 1'b0, clr, lk, er);
    end
  endtask

  task automatic reset_now();
    exp_t x;
    clrn = 1'b0;
    e8 = 8'd0; e2 = 2'd0; eb = 16'd0; pl = 1'b0;
    g = 7'h7F;
    x = '{lock: 1'b0, er: 1'b0, cnt: 8'd0, cnt_s: 2'd0, bits: 16'd0};
    sb.push_back(x);
    #2;
    compare_pop();
    @(posedge clk);
    #1;
    clrn = 1'b1;
  endtask

  initial begin
    int vc;
    din = 1'b0; din_valid = 1'b0; clr_cnt = 1'b0; clrn = 1'b1;
    #3;
    reset_now();

    // Clean lock: lock on the 15th valid bit, no errors over 200 bits.
    for (int n = 1; n <= 200; n++) gstep(1'b0, 1'b1, 1'b0, n >= 15, 1'b0);

    // Single error, then 50 clean bits.
    e8 = 8'd1; e2 = 2'd1;
    gstep(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    for (int n = 0; n < 50; n++) gstep(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);

    // Four more isolated errors: the 2-bit counter saturates at 3.
    for (int k = 0; k < 4; k++) begin
      e8 = e8 + 8'd1;
      e2 = (e2 == 2'd3) ? 2'd3 : e2 + 2'd1;
      gstep(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
      for (int n = 0; n < 3; n++) gstep(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    end

    // clr_cnt beats a simultaneous sixth error.
    e8 = 8'd0; e2 = 2'd0;
    gstep(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    for (int n = 0; n < 5; n++) gstep(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);

    // Lock loss on the 4th consecutive error, relock 15 clean bits later.
    for (int k = 1; k <= 4; k++) begin
      e8 = 8'(k);
      e2 = (k >= 3) ? 2'd3 : 2'(k);
      gstep(1'b1, 1'b1, 1'b0, k < 4, 1'b1);
    end
    for (int j = 1; j <= 20; j++) gstep(1'b0, 1'b1, 1'b0, j >= 15, 1'b0);

    // Mid-stream reset while locked, then a gapped-valid stream.
    reset_now();
    vc = 0;
    for (int c = 0; c < 40; c++) begin
      if (c % 2 == 0) vc++;
      gstep(1'b0, c % 2 == 0, 1'b0, vc >= 15, 1'b0);
    end

    // Reset again while locked, then all-zero data must never lock.
    reset_now();
    for (int n = 0; n < 40; n++) step_raw(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/prbs7_checker.md
# prbs7_checker

Synthesizable serial PRBS7 checker (x^7 + x^6 + 1) that receives a bit stream sampled one bit per valid clock and verifies it against a locally regenerated sequence. It is the receiving end of the team's serial stimulus path: bench or on-chip generators drive `din`, and this block reports lock status and error counts. It sits next to the flip-flop and register primitives as a self-checking sink in labs and regression benches.

## Interface
Parameters:
- LOCK_CNT, 8, consecutive matching bits required in CHECK before declaring lock (1..255)
- LOSS_CNT, 4, consecutive mismatches in LOCKED that drop lock (1..15)
- ERR_W, 8, width of the error counter

Ports:
- clk  in  1  clock; all state updates on the rising edge
- clrn  in  1  asynchronous, active-low reset
- din  in  1  serial data bit; sampled only when din_valid=1
- din_valid  in  1  qualifies din for this cycle
- clr_cnt  in  1  synchronous clear of err_cnt (and bit_cnt when compiled in)
- locked  out  1  1 while the FSM is in LOCKED
- err  out  1  one-cycle pulse per mismatching valid bit while LOCKED
- err_cnt  out  ERR_W  saturating count of mismatches while LOCKED

## Operation
- Shift register `s[6:0]`. Expected bit `e = s[6] ^ s[5]`. A shift means `s <= {s[5:0], x}`.
- Cycles with din_valid=0: no state change at all. Counters hold, and err=0.
- FSM states:
  - SEED: shift in din. After 7 valid bits, go to CHECK with the match counter set to 0.
  - CHECK: shift in din (self-synchronizing). If din==e, increment the match counter; when it reaches LOCK_CNT, go to LOCKED. If din!=e, go to SEED with the seed counter set to 0.
  - LOCKED: shift in e (free-running, so errors do not propagate).
    - din==e clears the loss counter.
    - din!=e raises err, increments err_cnt (saturating at all-ones) and increments the loss counter. When the loss counter reaches LOSS_CNT, go to SEED. err_cnt is kept.
- An all-zero `s` in CHECK or LOCKED is illegal (PRBS7 never produces it). Treat it as a mismatch in CHECK, and as a forced transition to SEED in LOCKED.
- clr_cnt=1 zeroes err_cnt on the next edge. It wins over a simultaneous increment. It does not affect the FSM.

## Timing
- Reset values (clrn=0, asynchronous): state=SEED, s=0, all internal counters 0, locked=0, err=0, err_cnt=0, bit_cnt=0.
- All outputs are registered.
- err is asserted for exactly the one cycle after the edge that sampled the bad bit.
- locked rises on the edge that samples the LOCK_CNT-th consecutive match. The earliest lock is the 7+LOCK_CNT-th valid bit after reset.
- locked falls on the edge that samples the LOSS_CNT-th consecutive mismatch. err is also 1 for that bit.
- Reset asserted mid-stream aborts immediately to the reset values. Nothing is retained.
- Gaps in din_valid of any length are transparent. Only valid bits count toward the thresholds.

## Configuration
- Macro: `PRBS7_CHECKER_BITCNT_EN`.
- When defined:
  - Adds output `bit_cnt  out  16`, a saturating count of valid bits sampled while LOCKED.
  - bit_cnt is cleared by reset and by clr_cnt.
  - bit_cnt holds when lock is lost.
- When undefined: the port and its logic are absent. All other behaviour is identical.

## Test plan
- Clean lock: reset, then drive a PRBS7 stream from generator state 7'h7F with din_valid=1 every cycle. Required: locked=1 after the 15th bit, err never pulses, err_cnt=0 after 200 bits.
- Single error: once locked, invert one bit. Required: one err pulse, err_cnt=1, locked stays 1, and the next 50 bits produce no further errors.
- Lock loss: once locked, invert 4 consecutive bits. Required: 4 err pulses and err_cnt=4. locked falls with the 4th error, relocks 15 valid bits after clean data resumes, and err_cnt remains 4.
- Gapped valid: same stream with din_valid toggling 1/0. Required: lock after 15 valid bits (about 30 cycles), and no errors.
- Saturation and clear: ERR_W=2, locked, inject 5 isolated errors. Required: err_cnt=3. Then clr_cnt=1 together with a 6th error gives err_cnt=0.
- Reset mid-stream plus all-zeros: pulse clrn=0 while locked. Required: all outputs 0 immediately. Then drive 40 zero bits: locked never asserts.
